// File: rtl/elgamal_pkg.sv
// Shared definitions for the ElGamal pipeline stages.
//   SIZE          : default operand width.
//   MULMOD_CYCLES : cycles taken by one modular multiplication (load + SIZE steps).
//   state_t       : decrypting_entity controller states.
package elgamal_pkg;

  localparam int SIZE          = 64;
  localparam int MULMOD_CYCLES = SIZE + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SQR   = 3'd2,
    ST_MUL   = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mod_mul_iter.sv
// Iterative modular multiplier: o_product = (y * z) mod p.
// Interleaved left-to-right shift-add, one multiplier bit per cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_start     : load operands (ignored while busy)
//   i_y, i_z    : operands, both expected < i_p
//   i_p         : modulus
//   o_busy      : iteration in progress
//   o_done      : high in the last iteration cycle; o_product is valid then
//   o_product   : result, always < p
// A multiplication spans W+1 cycles: the start cycle plus W iterations.
module mod_mul_iter #(
  parameter int W = elgamal_pkg::SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  input  logic [W-1:0] i_p,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_product
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     r_y;
  logic [W-1:0]     r_z;
  logic [W-1:0]     r_p;
  logic [W+1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [W+1:0] w_p_ext;
  logic [W+1:0] w_add;
  logic [W+1:0] w_dbl;
  logic [W+1:0] w_s1;
  logic [W+1:0] w_s2;

  // acc < p, so 2*acc + z < 3p: two subtractions bring it back below p,
  // and the two extra bits hold the intermediate without overflow.
  assign w_p_ext = {2'b00, r_p};
  assign w_add   = r_y[r_cnt] ? {2'b00, r_z} : '0;
  assign w_dbl   = (r_acc << 1) + w_add;
  assign w_s1    = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;
  assign w_s2    = (w_s1  >= w_p_ext) ? (w_s1  - w_p_ext) : w_s1;

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = w_s2[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y    <= '0;
      r_z    <= '0;
      r_p    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_y    <= i_y;
      r_z    <= i_z;
      r_p    <= i_p;
      r_acc  <= '0;
      r_cnt  <= CNT_W'(W - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_s2;
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/decrypting_entity.sv
// ElGamal decryption: m = b * a^(p-1-x) mod p, computed by square-and-multiply
// over all SIZE exponent bits with one shared iterative modular multiplier.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   input_{p,x_key,a,b}_*    : AXI-stream operands, accepted together in IDLE
//   output_m_*               : AXI-stream result; tuser flags an operand range error
// Handshake rule: a transfer happens in a cycle where tvalid and tready are both
// high; the four input readies rise only when all four input valids are high,
// and the result holds (tvalid, tdata, tuser stable) until output_m_tready.
// Optional build macro DECRYPT_RANGE_CHECK_EN: reject out-of-range operands in
// LOAD with m = 0 and tuser = 1; otherwise tuser is constant 0.
module decrypting_entity #(
  parameter int SIZE = elgamal_pkg::SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_p_tdata,
  input  logic            input_p_tvalid,
  output logic            input_p_tready,
  input  logic [SIZE-1:0] input_x_key_tdata,
  input  logic            input_x_key_tvalid,
  output logic            input_x_key_tready,
  input  logic [SIZE-1:0] input_a_tdata,
  input  logic            input_a_tvalid,
  output logic            input_a_tready,
  input  logic [SIZE-1:0] input_b_tdata,
  input  logic            input_b_tvalid,
  output logic            input_b_tready,
  output logic [SIZE-1:0] output_m_tdata,
  output logic            output_m_tuser,
  output logic            output_m_tvalid,
  input  logic            output_m_tready
);

  import elgamal_pkg::*;

  localparam int IDX_W = $clog2(SIZE);

  state_t            r_state;
  state_t            w_next;
  logic [SIZE-1:0]   r_p;
  logic [SIZE-1:0]   r_x;
  logic [SIZE-1:0]   r_a;
  logic [SIZE-1:0]   r_b;
  logic [SIZE-1:0]   r_e;
  logic [SIZE-1:0]   r_r;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err;

  logic              w_accept;
  logic              w_range_err;
  logic              w_mul_active;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [SIZE-1:0]   w_mul_z;
  logic [SIZE-1:0]   w_mul_prod;

  // rst gating keeps the readies low during reset regardless of state.
  assign w_accept = (r_state == ST_IDLE) && !rst &&
                    input_p_tvalid && input_x_key_tvalid &&
                    input_a_tvalid && input_b_tvalid;

  assign input_p_tready     = w_accept;
  assign input_x_key_tready = w_accept;
  assign input_a_tready     = w_accept;
  assign input_b_tready     = w_accept;

  assign output_m_tvalid = (r_state == ST_DONE);
  assign output_m_tdata  = (r_state == ST_DONE) ? r_r : '0;
  assign output_m_tuser  = (r_state == ST_DONE) && r_err;

`ifdef DECRYPT_RANGE_CHECK_EN
  // p >= 3 is assumed, so p-2 cannot wrap.
  assign w_range_err = (r_x > (r_p - SIZE'(2))) || (r_a == '0) ||
                       (r_a >= r_p) || (r_b >= r_p);
`else
  assign w_range_err = 1'b0;
`endif

  // The multiplier is kicked on the first cycle of every SQR/MUL/FINAL visit;
  // its done cycle is the last cycle of that visit.
  assign w_mul_active = (r_state == ST_SQR) || (r_state == ST_MUL) ||
                        (r_state == ST_FINAL);
  assign w_mul_start  = w_mul_active && !w_mul_busy;

  always_comb begin
    w_mul_z = r_r;
    case (r_state)
      ST_MUL:   w_mul_z = r_a;
      ST_FINAL: w_mul_z = r_b;
      default:  w_mul_z = r_r;
    endcase
  end

  mod_mul_iter #(.W(SIZE)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_y       (r_r),
    .i_z       (w_mul_z),
    .i_p       (r_p),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_LOAD;
      ST_LOAD:  w_next = w_range_err ? ST_DONE : ST_SQR;
      ST_SQR: begin
        if (w_mul_done) begin
          if (r_e[r_idx])          w_next = ST_MUL;
          else if (r_idx == '0)    w_next = ST_FINAL;
          else                     w_next = ST_SQR;
        end
      end
      ST_MUL: begin
        if (w_mul_done) w_next = (r_idx == '0) ? ST_FINAL : ST_SQR;
      end
      ST_FINAL: if (w_mul_done) w_next = ST_DONE;
      ST_DONE:  if (output_m_tready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
      r_x     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_e     <= '0;
      r_r     <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_p <= input_p_tdata;
            r_x <= input_x_key_tdata;
            r_a <= input_a_tdata;
            r_b <= input_b_tdata;
          end
        end
        ST_LOAD: begin
          // Fermat: a^-x = a^(p-1-x), so one exponentiation yields the inverse.
          r_e   <= r_p - SIZE'(1) - r_x;
          r_idx <= IDX_W'(SIZE - 1);
          r_r   <= w_range_err ? '0 : SIZE'(1);
          r_err <= w_range_err;
        end
        ST_SQR: begin
          if (w_mul_done) begin
            r_r <= w_mul_prod;
            // A set bit keeps idx for the following MUL, which decrements it.
            if (!r_e[r_idx] && (r_idx != '0)) r_idx <= r_idx - IDX_W'(1);
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_r <= w_mul_prod;
            if (r_idx != '0) r_idx <= r_idx - IDX_W'(1);
          end
        end
        ST_FINAL: if (w_mul_done) r_r <= w_mul_prod;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypting_entity.sv
module tb_decrypting_entity;
  import elgamal_pkg::*;

  localparam int W      = SIZE;
  localparam int BUDGET = 9000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [W-1:0] p_d, x_d, a_d, b_d;
  logic         p_v, x_v, a_v, b_v;
  logic         p_r, x_r, a_r, b_r;
  logic [W-1:0] m_d;
  logic         m_u, m_v, m_rdy;

  decrypting_entity #(.SIZE(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_p_tdata      (p_d),
    .input_p_tvalid     (p_v),
    .input_p_tready     (p_r),
    .input_x_key_tdata  (x_d),
    .input_x_key_tvalid (x_v),
    .input_x_key_tready (x_r),
    .input_a_tdata      (a_d),
    .input_a_tvalid     (a_v),
    .input_a_tready     (a_r),
    .input_b_tdata      (b_d),
    .input_b_tvalid     (b_v),
    .input_b_tready     (b_r),
    .output_m_tdata     (m_d),
    .output_m_tuser     (m_u),
    .output_m_tvalid    (m_v),
    .output_m_tready    (m_rdy)
  );

  wire [3:0] rdy = {p_r, x_r, a_r, b_r};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic int exp_lat(input logic [W-1:0] p, input logic [W-1:0] x);
    logic [W-1:0] e;
    e = p - 64'd1 - x;
    return 2 + (W + 1 + $countones(e)) * MULMOD_CYCLES;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] p, input logic [W-1:0] x,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    p_d = p; x_d = x; a_d = a; b_d = b;
    p_v = 1'b1; x_v = 1'b1; a_v = 1'b1; b_v = 1'b1;
  endtask

  task automatic idle_inputs();
    p_v = 1'b0; x_v = 1'b0; a_v = 1'b0; b_v = 1'b0;
  endtask

  // Presents one operand set; n is the handshake cycle, r the readies seen in it.
  task automatic send(input logic [W-1:0] p, input logic [W-1:0] x,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      output int n, output logic [3:0] r);
    drive(p, x, a, b);
    #1;
    r = rdy;
    n = cyc;
    step();
    idle_inputs();
  endtask

  task automatic wait_valid(input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_v === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    m_rdy = 1'b0;
    drive(64'd23, 64'd6, 64'd10, 64'd14);
    step(); step(); step();
    checks++;
    if (rdy !== 4'h0) begin
      failures++; $display("FAIL reset_ready got=%h exp=0", rdy);
    end
    checks++;
    if (m_v !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", m_v);
    end
    checks++;
    if (m_d !== '0) begin
      failures++; $display("FAIL reset_data got=%0d exp=0", m_d);
    end
    checks++;
    if (m_u !== 1'b0) begin
      failures++; $display("FAIL reset_user got=%b exp=0", m_u);
    end
    idle_inputs();
    rst = 1'b0;
    m_rdy = 1'b1;
    step();
  endtask

  task automatic test_textbook();
    int n, t; bit ok; logic [3:0] r; logic [W-1:0] e;
    exp_q.push_back(64'd10);
    send(64'd23, 64'd6, 64'd10, 64'd14, n, r);
    checks++;
    if (r !== 4'hf) begin
      failures++; $display("FAIL textbook_accept got=%h exp=f", r);
    end
    wait_valid(BUDGET, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      failures++; $display("FAIL textbook_timeout got=none exp=valid");
    end else begin
      checks++;
      if (t - n != exp_lat(64'd23, 64'd6)) begin
        failures++; $display("FAIL textbook_latency got=%0d exp=%0d", t - n, exp_lat(64'd23, 64'd6));
      end
      checks++;
      if (m_d !== e) begin
        failures++; $display("FAIL textbook_data got=%0d exp=%0d", m_d, e);
      end
      checks++;
      if (m_u !== 1'b0) begin
        failures++; $display("FAIL textbook_user got=%b exp=0", m_u);
      end
    end
    step();
    checks++;
    if (m_v !== 1'b0) begin
      failures++; $display("FAIL textbook_release got=%b exp=0", m_v);
    end
  endtask

  task automatic test_zero_key();
    int n, t; bit ok; logic [3:0] r;
    send(64'd23, 64'd0, 64'd10, 64'd14, n, r);
    wait_valid(BUDGET, t, ok);
    checks++;
    if (!ok || (t - n) != 4422) begin
      failures++; $display("FAIL zero_key_latency got=%0d ok=%b exp=4422", t - n, ok);
    end
    checks++;
    if (m_d !== 64'd14) begin
      failures++; $display("FAIL zero_key_data got=%0d exp=14", m_d);
    end
    step();
  endtask

  task automatic test_full_width();
    int n, t; bit ok; logic [3:0] r;
    logic [W-1:0] p;
    p = 64'h1FFF_FFFF_FFFF_FFFF;
    send(p, 64'd1, 64'd2, 64'd2, n, r);
    wait_valid(BUDGET, t, ok);
    checks++;
    if (!ok || (t - n) != exp_lat(p, 64'd1)) begin
      failures++; $display("FAIL full_width_latency got=%0d ok=%b exp=%0d", t - n, ok, exp_lat(p, 64'd1));
    end
    checks++;
    if (m_d !== 64'd1) begin
      failures++; $display("FAIL full_width_data got=%0d exp=1", m_d);
    end
    checks++;
    if (m_u !== 1'b0) begin
      failures++; $display("FAIL full_width_user got=%b exp=0", m_u);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, t, bad; bit ok; logic [3:0] r;
    m_rdy = 1'b0;
    send(64'd23, 64'd6, 64'd10, 64'd14, n, r);
    wait_valid(BUDGET, t, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL backpressure_timeout got=none exp=valid");
    end
    // Offer the next operand set while the result is stalled.
    drive(64'd23, 64'd6, 64'd10, 64'd14);
    #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (m_v !== 1'b1 || m_d !== 64'd10 || rdy !== 4'h0) begin
        failures++; bad++;
        if (bad < 4) $display("FAIL backpressure_hold cyc=%0d valid=%b data=%0d ready=%h exp=1/10/0", i, m_v, m_d, rdy);
      end
      step();
    end
    m_rdy = 1'b1;
    #1;
    checks++;
    if (m_v !== 1'b1 || rdy !== 4'h0) begin
      failures++; $display("FAIL output_handshake valid=%b ready=%h exp=1/0", m_v, rdy);
    end
    step();
    checks++;
    if (rdy !== 4'hf || m_v !== 1'b0) begin
      failures++; $display("FAIL next_accept ready=%h valid=%b exp=f/0", rdy, m_v);
    end
    n = cyc;
    step();
    idle_inputs();
    wait_valid(BUDGET, t, ok);
    checks++;
    if (!ok || (t - n) != 4292 || m_d !== 64'd10) begin
      failures++; $display("FAIL back_to_back got=%0d lat=%0d exp=10 lat=4292", m_d, t - n);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n, t, spurious; bit ok; logic [3:0] r;
    send(64'd23, 64'd6, 64'd10, 64'd14, n, r);
    for (int i = 0; i < 100; i++) step();
    rst = 1'b1;
    drive(64'd23, 64'd6, 64'd10, 64'd14);
    step();
    checks++;
    if (m_v !== 1'b0 || m_d !== '0 || m_u !== 1'b0 || rdy !== 4'h0) begin
      failures++; $display("FAIL mid_reset_outputs valid=%b data=%0d user=%b ready=%h exp=0", m_v, m_d, m_u, rdy);
    end
    step();
    idle_inputs();
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 5000; i++) begin
      if (m_v !== 1'b0) spurious++;
      step();
    end
    checks++;
    if (spurious != 0) begin
      failures++; $display("FAIL mid_reset_spurious got=%0d exp=0", spurious);
    end
    send(64'd23, 64'd6, 64'd10, 64'd14, n, r);
    wait_valid(BUDGET, t, ok);
    checks++;
    if (!ok || r !== 4'hf || (t - n) != 4292 || m_d !== 64'd10) begin
      failures++; $display("FAIL mid_reset_rerun got=%0d lat=%0d exp=10 lat=4292", m_d, t - n);
    end
    step();
  endtask

  task automatic test_range();
    int n, t; bit ok; logic [3:0] r;
    send(64'd23, 64'd22, 64'd10, 64'd14, n, r);
    wait_valid(BUDGET, t, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL range_timeout got=none exp=valid");
    end
`ifdef DECRYPT_RANGE_CHECK_EN
    // Handshake, LOAD, then DONE: result in the third cycle.
    checks++;
    if ((t - n) != 2 || m_d !== '0 || m_u !== 1'b1) begin
      failures++; $display("FAIL range_reject got=%0d user=%b lat=%0d exp=0/1/2", m_d, m_u, t - n);
    end
`else
    checks++;
    if (m_u !== 1'b0) begin
      failures++; $display("FAIL range_user got=%b exp=0", m_u);
    end
`endif
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    p_d = '0; x_d = '0; a_d = '0; b_d = '0;
    idle_inputs();
    m_rdy = 1'b0;
    test_reset();
    test_textbook();
    test_zero_key();
    test_full_width();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
